// File: rtl/keyboard_pkg.sv
// Shared scancode constants, decode FSM states and the set-2 to ASCII lookup
// for the PS/2 keyboard front end.
package keyboard_pkg;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  localparam logic [7:0] KEY_UP    = 8'h80;
  localparam logic [7:0] KEY_DOWN  = 8'h81;
  localparam logic [7:0] KEY_LEFT  = 8'h82;
  localparam logic [7:0] KEY_RIGHT = 8'h83;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StBreak    = 2'd1,
    StExt      = 2'd2,
    StExtBreak = 2'd3
  } kbd_state_e;

  // Letters follow shift XOR caps; digits/symbols follow shift alone (US layout).
  function automatic logic [7:0] sc_to_ascii(input logic [7:0] sc, input logic shift,
                                             input logic caps);
    logic [7:0] lower;
    logic [7:0] upper;
    logic       is_letter;
    lower     = 8'h00;
    upper     = 8'h00;
    is_letter = 1'b0;
    case (sc)
      8'h1C: begin lower = "a"; is_letter = 1'b1; end
      8'h32: begin lower = "b"; is_letter = 1'b1; end
      8'h21: begin lower = "c"; is_letter = 1'b1; end
      8'h23: begin lower = "d"; is_letter = 1'b1; end
      8'h24: begin lower = "e"; is_letter = 1'b1; end
      8'h2B: begin lower = "f"; is_letter = 1'b1; end
      8'h34: begin lower = "g"; is_letter = 1'b1; end
      8'h33: begin lower = "h"; is_letter = 1'b1; end
      8'h43: begin lower = "i"; is_letter = 1'b1; end
      8'h3B: begin lower = "j"; is_letter = 1'b1; end
      8'h42: begin lower = "k"; is_letter = 1'b1; end
      8'h4B: begin lower = "l"; is_letter = 1'b1; end
      8'h3A: begin lower = "m"; is_letter = 1'b1; end
      8'h31: begin lower = "n"; is_letter = 1'b1; end
      8'h44: begin lower = "o"; is_letter = 1'b1; end
      8'h4D: begin lower = "p"; is_letter = 1'b1; end
      8'h15: begin lower = "q"; is_letter = 1'b1; end
      8'h2D: begin lower = "r"; is_letter = 1'b1; end
      8'h1B: begin lower = "s"; is_letter = 1'b1; end
      8'h2C: begin lower = "t"; is_letter = 1'b1; end
      8'h3C: begin lower = "u"; is_letter = 1'b1; end
      8'h2A: begin lower = "v"; is_letter = 1'b1; end
      8'h1D: begin lower = "w"; is_letter = 1'b1; end
      8'h22: begin lower = "x"; is_letter = 1'b1; end
      8'h35: begin lower = "y"; is_letter = 1'b1; end
      8'h1A: begin lower = "z"; is_letter = 1'b1; end
      8'h45: {lower, upper} = "0)";
      8'h16: {lower, upper} = "1!";
      8'h1E: {lower, upper} = "2@";
      8'h26: {lower, upper} = "3#";
      8'h25: {lower, upper} = "4$";
      8'h2E: {lower, upper} = "5%";
      8'h36: {lower, upper} = "6^";
      8'h3D: {lower, upper} = "7&";
      8'h3E: {lower, upper} = "8*";
      8'h46: {lower, upper} = "9(";
      8'h0E: {lower, upper} = "`~";
      8'h4E: {lower, upper} = "-_";
      8'h55: {lower, upper} = "=+";
      8'h54: {lower, upper} = "[{";
      8'h5B: {lower, upper} = "]}";
      8'h5D: {lower, upper} = "\\|";
      8'h4C: {lower, upper} = ";:";
      8'h52: {lower, upper} = "'\"";
      8'h41: {lower, upper} = ",<";
      8'h49: {lower, upper} = ".>";
      8'h4A: {lower, upper} = "/?";
      8'h5A: {lower, upper} = {8'h0D, 8'h0D};
      8'h66: {lower, upper} = {8'h08, 8'h08};
      8'h29: {lower, upper} = {8'h20, 8'h20};
      8'h76: {lower, upper} = {8'h1B, 8'h1B};
      8'h0D: {lower, upper} = {8'h09, 8'h09};
      default: ;
    endcase
    if (is_letter) begin
      return (shift ^ caps) ? (lower - 8'd32) : lower;
    end
    return shift ? upper : lower;
  endfunction

endpackage

// File: rtl/key_fifo.sv
// Synchronous first-word fall-through FIFO; a pop on a full FIFO frees the
// slot that a same-cycle push then uses.
module key_fifo #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 8,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(Depth));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scancode parser: tracks Shift/Caps Lock, translates key presses
// to ASCII or nav codes and queues them for the keyboard MMIO port.
module ps2_key_decoder
  import keyboard_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        CLK_CPU,
  input  logic        resetp,
  input  logic [7:0]  scancode_byte,
  input  logic        scancode_valid,
  input  logic        clean_key_buffer,
  output logic [7:0]  pressed_key,
  output logic        keyboard_valid,
  output logic        key_overflow,
  output logic [31:0] debug
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  kbd_state_e      state_q, state_d;
  logic            shift_q, shift_d;
  logic            caps_q, caps_d;
  logic            overflow_q, overflow_d;
  logic [7:0]      last_byte_q, last_byte_d;
  logic            push_req;
  logic [7:0]      push_data;
  logic [7:0]      ascii;
  logic [7:0]      fifo_head;
  logic            fifo_full, fifo_empty;
  logic [CntW-1:0] fifo_count;

  assign ascii = sc_to_ascii(scancode_byte, shift_q, caps_q);

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    caps_d      = caps_q;
    last_byte_d = last_byte_q;
    push_req    = 1'b0;
    push_data   = 8'h00;
    if (scancode_valid) begin
      last_byte_d = scancode_byte;
      unique case (state_q)
        StIdle: begin
          if (scancode_byte == SC_EXT) begin
            state_d = StExt;
          end else if (scancode_byte == SC_BREAK) begin
            state_d = StBreak;
          end else if (scancode_byte == SC_LSHIFT || scancode_byte == SC_RSHIFT) begin
            shift_d = 1'b1;
          end else if (scancode_byte == SC_CAPS) begin
            caps_d = ~caps_q;
          end else begin
            push_req  = (ascii != 8'h00);
            push_data = ascii;
          end
        end
        StBreak: begin
          state_d = StIdle;
          if (scancode_byte == SC_LSHIFT || scancode_byte == SC_RSHIFT) begin
            shift_d = 1'b0;
          end
        end
        StExt: begin
          state_d = (scancode_byte == SC_BREAK) ? StExtBreak : StIdle;
          case (scancode_byte)
            8'h75:   begin push_req = 1'b1; push_data = KEY_UP;    end
            8'h72:   begin push_req = 1'b1; push_data = KEY_DOWN;  end
            8'h6B:   begin push_req = 1'b1; push_data = KEY_LEFT;  end
            8'h74:   begin push_req = 1'b1; push_data = KEY_RIGHT; end
            default: ;
          endcase
        end
        StExtBreak: state_d = StIdle;
        default:    state_d = StIdle;
      endcase
    end
  end

  // A full FIFO only drops the key when no pop is freeing a slot this cycle.
  assign overflow_d = overflow_q | (push_req & fifo_full & ~clean_key_buffer);

  always_ff @(posedge CLK_CPU) begin
    if (resetp) begin
      state_q     <= StIdle;
      shift_q     <= 1'b0;
      caps_q      <= 1'b0;
      overflow_q  <= 1'b0;
      last_byte_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      caps_q      <= caps_d;
      overflow_q  <= overflow_d;
      last_byte_q <= last_byte_d;
    end
  end

  key_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (8)
  ) u_key_fifo (
    .clk_i   (CLK_CPU),
    .rst_i   (resetp),
    .push_i  (push_req),
    .data_i  (push_data),
    .pop_i   (clean_key_buffer),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign pressed_key    = fifo_empty ? 8'h00 : fifo_head;
  assign keyboard_valid = ~fifo_empty;
  assign key_overflow   = overflow_q;
  assign debug          = {state_q, shift_q, caps_q, 4'(fifo_count), 16'h0000, last_byte_q};

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed self-checking bench for ps2_key_decoder with hand-computed expectations.
module tb_ps2_key_decoder;

  logic        CLK_CPU = 1'b0;
  logic        resetp = 1'b1;
  logic [7:0]  scancode_byte = 8'h00;
  logic        scancode_valid = 1'b0;
  logic        clean_key_buffer = 1'b0;
  logic [7:0]  pressed_key;
  logic        keyboard_valid;
  logic        key_overflow;
  logic [31:0] debug;

  int vectors = 0;
  int miscompares = 0;

  ps2_key_decoder #(.FIFO_DEPTH(8)) dut (
    .CLK_CPU          (CLK_CPU),
    .resetp           (resetp),
    .scancode_byte    (scancode_byte),
    .scancode_valid   (scancode_valid),
    .clean_key_buffer (clean_key_buffer),
    .pressed_key      (pressed_key),
    .keyboard_valid   (keyboard_valid),
    .key_overflow     (key_overflow),
    .debug            (debug)
  );

  always #5 CLK_CPU = ~CLK_CPU;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK_CPU);
    resetp = 1'b1;
    @(negedge CLK_CPU);
    resetp = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge CLK_CPU);
    scancode_byte  = b;
    scancode_valid = 1'b1;
    @(negedge CLK_CPU);
    scancode_valid = 1'b0;
  endtask

  task automatic pop();
    @(negedge CLK_CPU);
    clean_key_buffer = 1'b1;
    @(negedge CLK_CPU);
    clean_key_buffer = 1'b0;
  endtask

  task automatic send_and_pop(input logic [7:0] b);
    @(negedge CLK_CPU);
    scancode_byte    = b;
    scancode_valid   = 1'b1;
    clean_key_buffer = 1'b1;
    @(negedge CLK_CPU);
    scancode_valid   = 1'b0;
    clean_key_buffer = 1'b0;
  endtask

  function automatic logic [31:0] cnt(input logic [31:0] d);
    return {28'h0, d[27:24]};
  endfunction

  logic [7:0] keys_sc [9];
  logic [7:0] keys_ascii [9];

  initial begin
    keys_sc    = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};
    keys_ascii = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h69};

    // Reset state
    do_reset();
    check("rst_key", {24'h0, pressed_key}, 32'h00);
    check("rst_valid", {31'h0, keyboard_valid}, 32'h0);
    check("rst_ovf", {31'h0, key_overflow}, 32'h0);
    check("rst_debug", debug, 32'h0);

    // Reset mid-sequence discards the pending break
    send(8'hF0);
    check("brk_state", {30'h0, debug[31:30]}, 32'h1);
    do_reset();
    send(8'h1C);
    check("midrst_key", {24'h0, pressed_key}, 32'h61);
    check("midrst_valid", {31'h0, keyboard_valid}, 32'h1);
    check("midrst_last", {24'h0, debug[7:0]}, 32'h1C);

    // Make/break with Shift
    do_reset();
    send(8'h12);
    check("shift_bit", {31'h0, debug[29]}, 32'h1);
    check("shift_nopush", {31'h0, keyboard_valid}, 32'h0);
    send(8'h1C);
    check("shift_valid", {31'h0, keyboard_valid}, 32'h1);
    check("shift_key", {24'h0, pressed_key}, 32'h41);
    send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12); send(8'h1C);
    check("mb_count", cnt(debug), 32'd2);
    check("mb_shift_rel", {31'h0, debug[29]}, 32'h0);
    pop();
    check("mb_head2", {24'h0, pressed_key}, 32'h61);
    pop();
    check("mb_empty", {31'h0, keyboard_valid}, 32'h0);

    // Caps Lock with Shift
    do_reset();
    send(8'h58); send(8'hF0); send(8'h58);
    check("caps_bit", {31'h0, debug[28]}, 32'h1);
    send(8'h1C);
    send(8'h12); send(8'h1C);
    check("caps_count", cnt(debug), 32'd2);
    check("caps_head1", {24'h0, pressed_key}, 32'h41);
    pop();
    check("caps_head2", {24'h0, pressed_key}, 32'h61);

    // Digits ignore caps, follow shift; specials and unmapped
    do_reset();
    send(8'h58); send(8'h16);
    check("digit_caps", {24'h0, pressed_key}, 32'h31);
    pop();
    send(8'h12); send(8'h16);
    check("digit_shift", {24'h0, pressed_key}, 32'h21);
    pop();
    send(8'h5A);
    check("enter", {24'h0, pressed_key}, 32'h0D);
    pop();
    send(8'h05);
    check("unmapped", {31'h0, keyboard_valid}, 32'h0);

    // Extended keys
    do_reset();
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hE0); send(8'h11);
    check("ext_count", cnt(debug), 32'd1);
    check("ext_head", {24'h0, pressed_key}, 32'h80);
    check("ext_state", {30'h0, debug[31:30]}, 32'h0);
    pop();
    send(8'hE0); send(8'h74);
    check("ext_right", {24'h0, pressed_key}, 32'h83);

    // Full FIFO and overflow
    do_reset();
    for (int i = 0; i < 9; i++) send(keys_sc[i]);
    check("full_count", cnt(debug), 32'd8);
    check("full_ovf", {31'h0, key_overflow}, 32'h1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("full_pop%0d", i), {24'h0, pressed_key}, {24'h0, keys_ascii[i]});
      pop();
    end
    check("drain_valid", {31'h0, keyboard_valid}, 32'h0);
    check("drain_key", {24'h0, pressed_key}, 32'h00);
    check("drain_ovf_sticky", {31'h0, key_overflow}, 32'h1);

    // Simultaneous push and pop: one entry
    do_reset();
    send(8'h1C);
    send_and_pop(8'h32);
    check("pp1_count", cnt(debug), 32'd1);
    check("pp1_head", {24'h0, pressed_key}, 32'h62);

    // Simultaneous push and pop: empty
    do_reset();
    send_and_pop(8'h1C);
    check("pp0_count", cnt(debug), 32'd1);
    check("pp0_head", {24'h0, pressed_key}, 32'h61);

    // Simultaneous push and pop: full
    do_reset();
    for (int i = 0; i < 8; i++) send(keys_sc[i]);
    send_and_pop(keys_sc[8]);
    check("ppf_count", cnt(debug), 32'd8);
    check("ppf_ovf", {31'h0, key_overflow}, 32'h0);
    check("ppf_head", {24'h0, pressed_key}, 32'h62);
    for (int i = 0; i < 7; i++) pop();
    check("ppf_tail", {24'h0, pressed_key}, 32'h69);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
